// File: rtl/sram_pkg.sv
// sram_pkg: shared state encoding, pin-bundle widths and read-latency bounds for the SRAM responder
package sram_pkg;
   localparam int SRAM_ADDR_W  = 19;
   localparam int SRAM_DATA_W  = 16;
   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 15;
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WRITE_ACTIVE = 2'd1,
      READ_WAIT    = 2'd2,
      READ_DRIVE   = 2'd3
   } sram_state_t;
   function automatic int clamp_lat(input int lat);
      return lat < READ_LAT_MIN ? READ_LAT_MIN : lat > READ_LAT_MAX ? READ_LAT_MAX : lat;
   endfunction
endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if: SRAM address/control pin bundle; the SRAM_DQ data bus stays a separate inout pin
interface sram_responder_if;
   import sram_pkg::*;
   logic [SRAM_ADDR_W-1:0] SRAM_ADDR;
   logic                   SRAM_CE_N;
   logic                   SRAM_OE_N;
   logic                   SRAM_WE_N;
   logic                   SRAM_UB_N;
   logic                   SRAM_LB_N;
   modport master (output SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N);
   modport slave  (input  SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N);
endinterface

// File: rtl/sram_resp_mem.sv
// sram_resp_mem: single-port 2^ADDR_BITS x 16 block RAM, per-byte write enables, write-first synchronous read
module sram_resp_mem
   import sram_pkg::*;
#(
   parameter int ADDR_BITS = 10
) (
   input  logic                   clk,
   input  logic                   en,
   input  logic [1:0]             be,
   input  logic [ADDR_BITS-1:0]   addr,
   input  logic [SRAM_DATA_W-1:0] wdata,
   output logic [SRAM_DATA_W-1:0] rdata
);
   logic [SRAM_DATA_W-1:0] mem [2**ADDR_BITS];
   logic [SRAM_DATA_W-1:0] merged;
   // Word as it will read after this cycle's write, so a read of the written address sees new data
   always_comb merged = {be[1] ? wdata[15:8] : mem[addr][15:8], be[0] ? wdata[7:0] : mem[addr][7:0]};
   // Array update and registered read share the one port
   always_ff @(posedge clk) begin
      if (en) begin
         if (|be) mem[addr] <= merged;
         rdata <= merged;
      end
   end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: on-chip stand-in for the external async SRAM; write/read stats enabled by SRAM_RESP_STATS_EN
module sram_responder
   import sram_pkg::*;
#(
   parameter int ADDR_BITS = 10,
   parameter int READ_LAT  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   sram_responder_if.slave        bus,
   inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
   output logic [SRAM_DATA_W-1:0] debug0
);
   localparam logic [3:0] LAT_LOAD = 4'(clamp_lat(READ_LAT) - 1);
   sram_state_t            state, state_nxt;
   logic [ADDR_BITS-1:0]   s_addr, rd_addr, rd_addr_nxt, w_addr, mem_addr;
   logic [SRAM_DATA_W-1:0] s_dq, w_data, rdata;
   logic                   s_ce_n, s_oe_n, s_we_n, s_ub_n, s_lb_n;
   logic [1:0]             w_lanes;
   logic [3:0]             cnt, cnt_nxt;
   logic                   ce, oe, we, addr_chg, commit, rd_issue;
   logic                   unused_addr_hi;
   assign unused_addr_hi = ^bus.SRAM_ADDR[SRAM_ADDR_W-1:ADDR_BITS];
   // Stage S: every pin, including the DQ input, is registered once; reset parks it inactive
   always_ff @(posedge clk) begin
      if (reset) begin
         s_addr <= '0;
         s_dq   <= '0;
         s_ce_n <= 1'b1;
         s_oe_n <= 1'b1;
         s_we_n <= 1'b1;
         s_ub_n <= 1'b1;
         s_lb_n <= 1'b1;
      end else begin
         s_addr <= bus.SRAM_ADDR[ADDR_BITS-1:0];
         s_dq   <= SRAM_DQ;
         s_ce_n <= bus.SRAM_CE_N;
         s_oe_n <= bus.SRAM_OE_N;
         s_we_n <= bus.SRAM_WE_N;
         s_ub_n <= bus.SRAM_UB_N;
         s_lb_n <= bus.SRAM_LB_N;
      end
   end
   assign ce       = ~s_ce_n;
   assign oe       = ~s_oe_n;
   assign we       = ~s_we_n;
   assign addr_chg = s_addr != rd_addr;
   // Next state, read address and latency counter, plus the one-cycle memory strobes
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      rd_addr_nxt = rd_addr;
      commit      = 1'b0;
      rd_issue    = 1'b0;
      case (state)
         IDLE: begin
            if (ce && we) state_nxt = WRITE_ACTIVE;
            else if (ce && oe) begin
               state_nxt   = READ_WAIT;
               rd_addr_nxt = s_addr;
               cnt_nxt     = LAT_LOAD;
            end
         end
         WRITE_ACTIVE: begin
            if (!ce || !we) begin
               commit    = 1'b1;
               state_nxt = IDLE;
            end
         end
         READ_WAIT, READ_DRIVE: begin
            if (!ce) state_nxt = IDLE;
            else if (we) state_nxt = WRITE_ACTIVE;
            else if (!oe) state_nxt = IDLE;
            else if (addr_chg) begin
               state_nxt   = READ_WAIT;
               rd_addr_nxt = s_addr;
               cnt_nxt     = LAT_LOAD;
            end else if (state == READ_WAIT) begin
               if (cnt == '0) begin
                  rd_issue  = 1'b1;
                  state_nxt = READ_DRIVE;
               end else cnt_nxt = cnt - 4'd1;
            end
         end
      endcase
   end
   // State, read address and counter; reset drops any pending write by returning to IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         rd_addr <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         rd_addr <= rd_addr_nxt;
      end
   end
   // Write capture every active cycle; the last one before the pulse ends is what commits
   always_ff @(posedge clk) begin
      if (ce && we) begin
         w_addr  <= s_addr;
         w_data  <= s_dq;
         w_lanes <= {~s_ub_n, ~s_lb_n};
      end
   end
   assign mem_addr = (state == WRITE_ACTIVE) ? w_addr : rd_addr;
   sram_resp_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
      .clk   (clk),
      .en    (commit | rd_issue),
      .be    (commit ? w_lanes : 2'b00),
      .addr  (mem_addr),
      .wdata (w_data),
      .rdata (rdata)
   );
   assign SRAM_DQ = (state == READ_DRIVE) ? rdata : 'z;
`ifdef SRAM_RESP_STATS_EN
   logic [7:0] write_cnt, read_cnt;
   // Saturating counts of committed writes and entries to READ_DRIVE
   always_ff @(posedge clk) begin
      if (reset) begin
         write_cnt <= '0;
         read_cnt  <= '0;
      end else begin
         if (commit && |w_lanes && write_cnt != 8'hFF) write_cnt <= write_cnt + 8'd1;
         if (rd_issue && read_cnt != 8'hFF) read_cnt <= read_cnt + 8'd1;
      end
   end
   assign debug0 = {write_cnt, read_cnt};
`else
   assign debug0 = {14'h0000, state};
`endif
endmodule
